// File: rtl/hwag_vrgen_pkg.sv
// Register map, reset values and control-register bit positions for the VR crank-wheel generator.
package hwag_vrgen_pkg;

  localparam int ADDR_CR   = 0;
  localparam int ADDR_PSC  = 1;
  localparam int ADDR_PER  = 2;
  localparam int ADDR_TNB  = 3;
  localparam int ADDR_MIS  = 4;
  localparam int ADDR_TST  = 5;
  localparam int ADDR_CAMT = 6;

  localparam int RST_PSC = 0;
  localparam int RST_PER = 63;
  localparam int RST_TNB = 57;
  localparam int RST_MIS = 2;
  localparam int RST_TST = 0;

  localparam int CR_EN      = 0;
  localparam int CR_RESTART = 1;

endpackage

// File: rtl/hwag_vrgen_tick.sv
// Prescaler: one-clk tick every PSC+1 clks; clear restarts the count.
// Tick is combinational from the counter register; no backpressure.
module hwag_vrgen_tick #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [DW-1:0] psc,
  output logic          tick
);

  logic [DW-1:0] scnt;

  // >= rather than == so a PSC lowered below the running count still ticks promptly
  assign tick = (scnt >= psc);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      scnt <= '0;
    end else if (tick) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

endmodule

// File: rtl/hwag_vrgen.sv
// Missing-tooth VR crank signal generator with ssram-style register bus; cam output under HWAG_VRGEN_CAM_EN.
// Read data 1 clk after ssram_re; start/stop act on the CR write edge; no backpressure.
module hwag_vrgen
  import hwag_vrgen_pkg::*;
#(
  parameter int CW = 24,
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ssram_we,
  input  logic          ssram_re,
  input  logic [AW-1:0] ssram_addr,
  input  logic [DW-1:0] ssram_wdata,
  output logic [DW-1:0] ssram_rdata,
  output logic          vr_out,
  output logic [7:0]    tooth,
  output logic          sync,
  output logic          cam_out
);

  logic          en;
  logic [DW-1:0] psc_r;
  logic [DW-1:0] per_r;
  logic [DW-1:0] tnb_r;
  logic [DW-1:0] mis_r;
  logic [7:0]    tst_r;

  logic [DW-1:0] act_per;
  logic [DW-1:0] act_tnb;
  logic [DW-1:0] act_mis;
  logic [CW-1:0] tckc;

  logic          wr_cr;
  logic          en_nxt;
  logic          start;
  logic          clear;
  logic          run;
  logic          tick;
  logic          boundary;
  logic          at_tnb;
  logic [DW-1:0] per_eff;
  logic [CW-1:0] top;
  logic [CW-1:0] half;
  logic [DW-1:0] rd_val;

`ifdef HWAG_VRGEN_CAM_EN
  logic [7:0]    camt_r;
  logic          rev;
`endif

  // Enable changes take effect on the write edge itself, so stop/start are not delayed a clk
  assign wr_cr  = ssram_we && (ssram_addr == AW'(ADDR_CR));
  assign en_nxt = wr_cr ? ssram_wdata[CR_EN] : en;
  assign start  = wr_cr && ssram_wdata[CR_EN] && (!en || ssram_wdata[CR_RESTART]);
  assign clear  = start || !en_nxt;
  assign run    = !clear;

  hwag_vrgen_tick #(
    .DW(DW)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .psc   (psc_r),
    .tick  (tick)
  );

  // A tooth shorter than two ticks has no high phase, so PER=0 behaves as PER=1
  assign per_eff  = (act_per == '0) ? DW'(1) : act_per;
  assign at_tnb   = (DW'(tooth) == act_tnb);
  assign top      = (DW'(tooth) < act_tnb)
                    ? CW'(per_eff)
                    : (CW'(act_mis) + CW'(1)) * (CW'(per_eff) + CW'(1)) - CW'(1);
  assign half     = top >> 1;
  assign boundary = run && tick && (tckc == top);

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      psc_r  <= DW'(RST_PSC);
      per_r  <= DW'(RST_PER);
      tnb_r  <= DW'(RST_TNB);
      mis_r  <= DW'(RST_MIS);
      tst_r  <= 8'(RST_TST);
`ifdef HWAG_VRGEN_CAM_EN
      camt_r <= '0;
`endif
    end else if (ssram_we) begin
      case (ssram_addr)
        AW'(ADDR_CR):   en    <= ssram_wdata[CR_EN];
        AW'(ADDR_PSC):  psc_r <= ssram_wdata;
        AW'(ADDR_PER):  per_r <= ssram_wdata;
        AW'(ADDR_TNB):  tnb_r <= ssram_wdata;
        AW'(ADDR_MIS):  mis_r <= ssram_wdata;
        AW'(ADDR_TST):  tst_r <= ssram_wdata[7:0];
`ifdef HWAG_VRGEN_CAM_EN
        AW'(ADDR_CAMT): camt_r <= ssram_wdata[7:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (ssram_addr)
      AW'(ADDR_CR):   rd_val[CR_EN] = en;
      AW'(ADDR_PSC):  rd_val = psc_r;
      AW'(ADDR_PER):  rd_val = per_r;
      AW'(ADDR_TNB):  rd_val = tnb_r;
      AW'(ADDR_MIS):  rd_val = mis_r;
      AW'(ADDR_TST):  rd_val = DW'(tst_r);
`ifdef HWAG_VRGEN_CAM_EN
      AW'(ADDR_CAMT): rd_val = DW'(camt_r);
`else
      AW'(ADDR_CAMT): rd_val = '0;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || ssram_we) begin
      ssram_rdata <= '0;
    end else if (ssram_re) begin
      ssram_rdata <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tckc    <= '0;
      vr_out  <= 1'b0;
      tooth   <= '0;
      sync    <= 1'b0;
      act_per <= DW'(RST_PER);
      act_tnb <= DW'(RST_TNB);
      act_mis <= DW'(RST_MIS);
    end else begin
      sync <= 1'b0;
      if (!en_nxt) begin
        tckc   <= '0;
        vr_out <= 1'b0;
        tooth  <= tst_r;
      end else if (start) begin
        tckc    <= '0;
        vr_out  <= 1'b0;
        tooth   <= tst_r;
        act_per <= per_r;
        act_tnb <= tnb_r;
        act_mis <= mis_r;
      end else if (tick) begin
        if (boundary) begin
          tckc    <= '0;
          vr_out  <= 1'b0;
          // tooth past a shrunk TNB also wraps here, but only a true TNB wrap pulses sync
          tooth   <= (DW'(tooth) >= act_tnb) ? 8'd0 : tooth + 8'd1;
          sync    <= at_tnb;
          act_per <= per_r;
          act_tnb <= tnb_r;
          act_mis <= mis_r;
        end else begin
          if (tckc == half) begin
            vr_out <= 1'b1;
          end
          tckc <= tckc + 1'b1;
        end
      end
    end
  end

`ifdef HWAG_VRGEN_CAM_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rev <= 1'b0;
    end else if (boundary && at_tnb) begin
      rev <= ~rev;
    end
  end

  assign cam_out = rev && (tooth == camt_r);
`else
  assign cam_out = 1'b0;
`endif

endmodule

// File: tb/tb_hwag_vrgen.sv
// Bench for hwag_vrgen: directed register/timing steps plus randomized wheel configs against a tooth-level model.
module tb_hwag_vrgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ssram_we;
  logic        ssram_re;
  logic [7:0]  ssram_addr;
  logic [15:0] ssram_wdata;
  logic [15:0] ssram_rdata;
  logic        vr_out;
  logic [7:0]  tooth;
  logic        sync;
  logic        cam_out;

  int n_cmp = 0;
  int n_err = 0;
  int first_sync;
  int second_sync;

  typedef struct packed {
    logic       vr;
    logic [7:0] tooth;
    logic       sync;
    logic       cam;
  } smp_t;

  smp_t exp_q[$];

  hwag_vrgen #(.CW(24), .AW(8), .DW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ssram_we    (ssram_we),
    .ssram_re    (ssram_re),
    .ssram_addr  (ssram_addr),
    .ssram_wdata (ssram_wdata),
    .ssram_rdata (ssram_rdata),
    .vr_out      (vr_out),
    .tooth       (tooth),
    .sync        (sync),
    .cam_out     (cam_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    ssram_we    = 1'b1;
    ssram_addr  = 8'(a);
    ssram_wdata = 16'(d);
    step();
    ssram_we    = 1'b0;
  endtask

  task automatic rd(input int a, output int d);
    ssram_re   = 1'b1;
    ssram_addr = 8'(a);
    step();
    ssram_re   = 1'b0;
    d          = int'(ssram_rdata);
  endtask

  task automatic wait_change(input int from, input int lim, output int cnt);
    cnt = 0;
    while (int'(tooth) == from && cnt < lim) begin
      step();
      cnt++;
    end
  endtask

  // Expected per-clk stream from the wheel description: each tooth is a low run then a high run,
  // lengths in clks from the tooth period; sync marks the first clk of tooth 0 after a wrap.
  task automatic build(input int psc, input int per, input int tnb, input int mis,
                       input int tst, input int camt, input int nmax);
    int  t;
    int  pe;
    bit  rev;
    bit  wrapped;
    t       = tst;
    pe      = (per < 1) ? 1 : per;
    rev     = 1'b0;
    wrapped = 1'b0;
    exp_q.delete();
    while (exp_q.size() < nmax) begin
      int top;
      int lo;
      int hi;
      top = (t < tnb) ? pe : (mis + 1) * (pe + 1) - 1;
      lo  = (top / 2 + 1) * (psc + 1);
      hi  = (top - top / 2) * (psc + 1);
      for (int i = 0; i < lo + hi; i++) begin
        smp_t s;
        s.vr    = (i >= lo);
        s.tooth = 8'(t);
        s.sync  = (i == 0) && wrapped;
`ifdef HWAG_VRGEN_CAM_EN
        s.cam   = rev && (t == camt);
`else
        s.cam   = 1'b0;
`endif
        exp_q.push_back(s);
      end
      if (t >= tnb) begin
        t       = 0;
        wrapped = 1'b1;
        rev     = !rev;
      end else begin
        t++;
        wrapped = 1'b0;
      end
    end
  endtask

  task automatic run_trial(input string tag, input int psc, input int per, input int tnb,
                           input int mis, input int tst, input int camt, input int nclk);
    smp_t obs;
    int   e0;
    wr(0, 0);
    wr(1, psc);
    wr(2, per);
    wr(3, tnb);
    wr(4, mis);
    wr(5, tst);
    wr(6, camt);
    step();
    chk({tag, "_idle_tooth"}, int'(tooth), tst);
    chk({tag, "_idle_vr"}, int'(vr_out), 0);
    build(psc, per, tnb, mis, tst, camt, nclk);
    first_sync  = -1;
    second_sync = -1;
    wr(0, 1);
    e0 = n_err;
    for (int n = 0; n < nclk; n++) begin
      obs = {vr_out, tooth, sync, cam_out};
      if (obs.sync) begin
        if (first_sync < 0) first_sync = n;
        else if (second_sync < 0) second_sync = n;
      end
      n_cmp++;
      assert (obs === exp_q[n]) else begin
        n_err++;
        $error("FAIL %s clk %0d: observed vr/tooth/sync/cam %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
               tag, n, obs.vr, obs.tooth, obs.sync, obs.cam,
               exp_q[n].vr, exp_q[n].tooth, exp_q[n].sync, exp_q[n].cam);
      end
      if (n_err != e0) break;
      step();
    end
  endtask

  initial begin
    int d;
    int c;
    int rst_vals[7];
    rst_vals = '{0, 0, 63, 57, 2, 0, 0};
    rst         = 1'b1;
    ssram_we    = 1'b0;
    ssram_re    = 1'b0;
    ssram_addr  = '0;
    ssram_wdata = '0;
    repeat (3) step();
    chk("rst_vr", int'(vr_out), 0);
    chk("rst_sync", int'(sync), 0);
    chk("rst_tooth", int'(tooth), 0);
    chk("rst_cam", int'(cam_out), 0);
    chk("rst_rdata", int'(ssram_rdata), 0);
    rst = 1'b0;
    step();

    // register file reset values and bus corner cases
    for (int a = 0; a < 7; a++) begin
      rd(a, d);
      chk($sformatf("reg%0d_reset", a), d, rst_vals[a]);
    end
    rd(9, d);
    chk("unmapped_read", d, 0);
    wr(9, 16'hbeef);
    rd(9, d);
    chk("unmapped_write", d, 0);
    ssram_we    = 1'b1;
    ssram_re    = 1'b1;
    ssram_addr  = 8'd1;
    ssram_wdata = 16'd5;
    step();
    ssram_we    = 1'b0;
    ssram_re    = 1'b0;
    chk("we_re_rdata", int'(ssram_rdata), 0);
    rd(1, d);
    chk("we_re_written", d, 5);
    wr(0, 3);
    rd(0, d);
    chk("cr_restart_reads0", d, 1);
    wr(0, 0);
    wr(6, 10);
    rd(6, d);
`ifdef HWAG_VRGEN_CAM_EN
    chk("camt_read", d, 10);
`else
    chk("camt_read", d, 0);
`endif

    // nominal 60-2 wheel, PSC=3, starting at tooth 45
    run_trial("t2", 3, 63, 57, 2, 45, 0, 3840 + 15360 + 16);
    chk("t2_first_sync", first_sync, 3840);
    chk("t2_sync_period", second_sync - first_sync, 15360);

    // shortest tooth, PER 1 and PER 0 identical; TNB 0 makes every tooth long
    run_trial("t3_per1", 0, 1, 5, 1, 0, 0, 80);
    run_trial("t3_per0", 0, 0, 5, 1, 0, 0, 80);
    run_trial("tnb0", 1, 3, 0, 1, 0, 0, 200);

    for (int k = 0; k < 5; k++) begin
      int ps;
      int pe;
      int tn;
      int mi;
      int ts;
      int ca;
      ps = int'($urandom_range(0, 2));
      pe = int'($urandom_range(0, 12));
      tn = int'($urandom_range(0, 12));
      mi = int'($urandom_range(0, 3));
      ts = int'($urandom_range(0, tn));
      ca = int'($urandom_range(0, tn));
      run_trial($sformatf("rnd%0d", k), ps, pe, tn, mi, ts, ca, 1500);
    end

    run_trial("t6_cam", 0, 3, 15, 1, 0, 10, 600);

    // PER rewritten mid-tooth takes effect from the next tooth
    wr(0, 0);
    wr(1, 3);
    wr(2, 63);
    wr(3, 57);
    wr(4, 2);
    wr(5, 0);
    wr(0, 1);
    repeat (99) step();
    wr(2, 31);
    wait_change(0, 400, c);
    chk("t4_tooth0_clks", 100 + c, 256);
    wait_change(1, 400, c);
    chk("t4_tooth1_clks", c, 128);

    // stop mid-tooth, restart at TST, restart while running
    wr(0, 0);
    wr(1, 0);
    wr(2, 7);
    wr(3, 20);
    wr(4, 1);
    wr(5, 3);
    wr(0, 1);
    c = 0;
    while (!vr_out && c < 100) begin
      step();
      c++;
    end
    chk("t5_vr_high_at", c, 4);
    step();
    wr(0, 0);
    chk("t5_stop_vr", int'(vr_out), 0);
    chk("t5_stop_tooth", int'(tooth), 3);
    chk("t5_stop_sync", int'(sync), 0);
    wr(5, 6);
    step();
    chk("t5_idle_tst", int'(tooth), 6);
    wr(0, 3);
    chk("t5_restart_tooth", int'(tooth), 6);
    chk("t5_restart_vr", int'(vr_out), 0);
    rd(0, d);
    chk("t5_cr_read", d, 1);
    wait_change(6, 100, c);
    chk("t5_first_tooth_clks", 1 + c, 8);
    repeat (5) step();
    chk("t5_mid_vr", int'(vr_out), 1);
    wr(0, 3);
    chk("t5_rerun_tooth", int'(tooth), 6);
    chk("t5_rerun_vr", int'(vr_out), 0);
    wait_change(6, 100, c);
    chk("t5_rerun_clks", c, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
